// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of clock steps needed to sum a full operand.
  function automatic int steps(input int width, input int bpc);
    return width / bpc;
  endfunction

  // Step counter width; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_chunk.sv
// Combinational BPC-bit ripple-carry slice built from 1-bit full-adder cells.
module serial_adder_chunk #(
  parameter int BPC = 1
) (
  input  logic [BPC-1:0] x,
  input  logic [BPC-1:0] y,
  input  logic           ci,
  output logic [BPC-1:0] s,
  output logic           co
);

  logic [BPC:0] c;

  assign c[0] = ci;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < BPC; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[BPC];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: sums BITS_PER_CYCLE bits per clock through a registered carry.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the 'sub' port (a - b - cin).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE and the
// result stays stable until the edge where out_ready is seen high.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output state_e           dbg_state
);

  localparam int STEPS = steps(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = cnt_width(STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("serial_adder: BITS_PER_CYCLE must divide WIDTH");
  end

  logic sub_eff;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          a_q, a_d;
  logic [WIDTH-1:0]          b_q, b_d;
  logic                      carry_q, carry_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]          work_q, work_d;
  logic [WIDTH-1:0]          sum_q, sum_d;
  logic                      cout_q, cout_d;

  logic [BITS_PER_CYCLE-1:0] chunk_s;
  logic                      chunk_co;
  logic [WIDTH+BITS_PER_CYCLE-1:0] work_cat;
  logic [WIDTH-1:0]          work_next;

  serial_adder_chunk #(
    .BPC (BITS_PER_CYCLE)
  ) u_chunk (
    .x  (a_q[BITS_PER_CYCLE-1:0]),
    .y  (b_q[BITS_PER_CYCLE-1:0]),
    .ci (carry_q),
    .s  (chunk_s),
    .co (chunk_co)
  );

  // New chunk enters the working sum from the MSB end.
  assign work_cat  = {chunk_s, work_q};
  assign work_next = work_cat[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];

  // Next-state logic: accept in IDLE, one chunk per edge in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtract is a + ~b + ~cin, so fold the inversion in at latch time.
          a_d     = a;
          b_d     = sub_eff ? ~b : b;
          carry_d = cin ^ sub_eff;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> BITS_PER_CYCLE;
        b_d     = b_q >> BITS_PER_CYCLE;
        carry_d = chunk_co;
        work_d  = work_next;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == LAST_STEP) begin
          // Result registers change only here, so they hold across IDLE.
          sum_d   = work_next;
          cout_d  = chunk_co;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;

endmodule
